// File: rtl/dice_pkg.sv
// Shared types and lookup tables for the dice roll controller.
package dice_pkg;

    localparam int RESULT_W = 7;
    localparam int DIE_W    = 3;
    localparam int NUM_DICE = 7;

    localparam logic [DIE_W-1:0] D4          = 3'd0;
    localparam logic [DIE_W-1:0] D6          = 3'd1;
    localparam logic [DIE_W-1:0] D8          = 3'd2;
    localparam logic [DIE_W-1:0] D10         = 3'd3;
    localparam logic [DIE_W-1:0] D12         = 3'd4;
    localparam logic [DIE_W-1:0] D20         = 3'd5;
    localparam logic [DIE_W-1:0] D100        = 3'd6;
    localparam logic [DIE_W-1:0] DIE_INVALID = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        SAMPLE,
        DONE
    } state_t;

    function automatic logic [RESULT_W-1:0] die_sides(input logic [DIE_W-1:0] d);
        case (d)
            D4:      return 7'd4;
            D6:      return 7'd6;
            D8:      return 7'd8;
            D10:     return 7'd10;
            D12:     return 7'd12;
            D20:     return 7'd20;
            D100:    return 7'd100;
            default: return 7'd1;
        endcase
    endfunction

    // Smallest all-ones mask covering N-1, so every masked value is below 2N.
    function automatic logic [RESULT_W-1:0] die_mask(input logic [DIE_W-1:0] d);
        case (d)
            D4:      return 7'd3;
            D6:      return 7'd7;
            D8:      return 7'd7;
            D10:     return 7'd15;
            D12:     return 7'd15;
            D20:     return 7'd31;
            D100:    return 7'd127;
            default: return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/dice_roll_sched_if.sv
// Roll request / result bundle between the I2C register file and the roll controller.
interface dice_roll_sched_if;
    import dice_pkg::*;

    logic                i2c_roll_req;
    logic [DIE_W-1:0]    i2c_roll_die;
    logic                i2c_roll_ack;
    logic [DIE_W-1:0]    die_sel;
    logic [RESULT_W-1:0] result;
    logic                result_valid;

    modport master (
        output i2c_roll_req, i2c_roll_die,
        input  i2c_roll_ack, die_sel, result, result_valid
    );

    modport slave (
        input  i2c_roll_req, i2c_roll_die,
        output i2c_roll_ack, die_sel, result, result_valid
    );

endinterface

// File: rtl/dice_roll_sched_btn_sync_prio.sv
// Two-flop button synchronizers followed by a lowest-index-wins priority encoder.
module btn_sync_prio
    import dice_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_DICE-1:0] btn_i,
    output logic [NUM_DICE-1:0] sbtn_o,
    output logic                any_o,
    output logic [DIE_W-1:0]    idx_o
);

    logic [NUM_DICE-1:0] meta_q;
    logic [NUM_DICE-1:0] sync_q;
    logic                found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
        end
    end

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_DICE; i++) begin
            if (sync_q[i] && !found) begin
                idx_o = DIE_W'(i);
                found = 1'b1;
            end
        end
    end

    assign sbtn_o = sync_q;
    assign any_o  = |sync_q;

endmodule

// File: rtl/dice_roll_sched.sv
// Roll controller: arbitrates button and I2C roll requests and sequences the shared roll datapath.
module dice_roll_sched
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_TRIES       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [NUM_DICE-1:0] btn,
    input  logic [RESULT_W-1:0] rnd,
    output logic                lfsr_step,
    output logic                rolling,
    output logic                busy,
    dice_roll_sched_if.slave    roll
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);

    state_t              state_q;
    logic [DIE_W-1:0]    die_q;
    logic [RESULT_W-1:0] result_q;
    logic [RESULT_W-1:0] cnt_q;
    logic [RESULT_W-1:0] cnt_d;
    logic [DW-1:0]       dcnt_q;
    logic [TW-1:0]       tries_q;
    logic                valid_q;
    logic                ack_q;

    logic [NUM_DICE-1:0] sbtn;
    logic [7:0]          sbtn_ext;
    logic                any_btn;
    logic [DIE_W-1:0]    btn_idx;
    logic [RESULT_W-1:0] sides;
    logic [RESULT_W-1:0] masked;
    logic                sel_btn;
    logic                accept;
    logic                last_try;
    logic                req_ok;

    btn_sync_prio u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn),
        .sbtn_o (sbtn),
        .any_o  (any_btn),
        .idx_o  (btn_idx)
    );

    assign sbtn_ext = {1'b0, sbtn};

    always_comb begin
        sides    = die_sides(die_q);
        masked   = rnd & die_mask(die_q);
        sel_btn  = sbtn_ext[die_q];
        accept   = masked < sides;
        last_try = tries_q == TRIES_LAST;
        cnt_d    = (cnt_q == sides) ? 7'd1 : cnt_q + 7'd1;
        // A request is still visible in the cycle its ack is out; do not take it twice.
        req_ok   = roll.i2c_roll_req && !ack_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            die_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            dcnt_q   <= '0;
            tries_q  <= '0;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            if (!ena) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (any_btn) begin
                            die_q   <= btn_idx;
                            dcnt_q  <= '0;
                            state_q <= DEBOUNCE;
                        end else if (req_ok && roll.i2c_roll_die != DIE_INVALID) begin
                            die_q   <= roll.i2c_roll_die;
                            tries_q <= '0;
                            state_q <= SAMPLE;
                        end else if (req_ok) begin
                            ack_q <= 1'b1;
                        end
                    end
                    DEBOUNCE: begin
                        if (!sel_btn) begin
                            state_q <= IDLE;
                        end else if (dcnt_q == DCNT_LAST) begin
                            cnt_q   <= 7'd1;
                            state_q <= HELD;
                        end else begin
                            dcnt_q <= dcnt_q + DW'(1);
                        end
                    end
                    HELD: begin
                        if (sel_btn) begin
                            cnt_q <= cnt_d;
                        end else begin
                            result_q <= cnt_q;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                    SAMPLE: begin
                        if (accept || last_try) begin
                            result_q <= accept ? masked + 7'd1 : masked - sides + 7'd1;
                            valid_q  <= 1'b1;
                            ack_q    <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            tries_q <= tries_q + TW'(1);
                        end
                    end
                    DONE: begin
                        if (!any_btn) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy              = ena && (state_q != IDLE);
    assign rolling           = ena && (state_q == HELD);
    assign lfsr_step         = ena && (state_q == SAMPLE) && (accept || !last_try);
    assign roll.result       = result_q;
    assign roll.die_sel      = die_q;
    assign roll.result_valid = valid_q && ena;
    assign roll.i2c_roll_ack = ack_q && ena;

endmodule
